// File: rtl/grostl_pkg.sv
// Shared types and ShiftBytes row offsets for the column-serial Groestl-256 datapath.
package grostl_pkg;

    typedef logic [0:7][7:0] col_t;
    typedef col_t [0:7]      state_t;

    // Cyclic column offset applied to each row, index = row.
    localparam logic [0:7][2:0] SHIFT_P = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [0:7][2:0] SHIFT_Q = {3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6};

    function automatic logic [2:0] row_shift(input logic sel_q, input logic [2:0] row);
        return sel_q ? SHIFT_Q[row] : SHIFT_P[row];
    endfunction

endpackage

// File: rtl/grostl_col_bank.sv
// One 8x8-byte state buffer: column write port plus the row-shifted column read mux.
module grostl_col_bank
    import grostl_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [2:0]      widx,
    input  logic [0:7][7:0] din,
    input  logic            sel_q_in,
    input  logic [2:0]      ridx,
    output logic [0:7][7:0] dout,
    output logic            sel_q
);

    state_t     mem;
    logic [2:0] row_idx [0:7];

    // The permutation select travels with column 0 so it always matches the stored state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem   <= '0;
            sel_q <= 1'b0;
        end else if (we) begin
            mem[widx] <= din;
            if (widx == 3'd0)
                sel_q <= sel_q_in;
        end
    end

    // Row i of output column ridx comes from column ridx + shift(i), wrapping mod 8.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            row_idx[i] = ridx + row_shift(sel_q, 3'(i));
            dout[i]    = mem[row_idx[i]][i];
        end
    end

endmodule

// File: rtl/grostl_shift_bytes.sv
// Column-serial ShiftBytes stage: ping-pong state banks, one column per cycle, 8-cycle latency.
module grostl_shift_bytes
    import grostl_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sel_q,
    input  logic [0:7][7:0] din,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_sel_q,
    output logic [0:7][7:0] dout
);

    // Handshake: a column transfers on a rising edge where valid & ready are both high.
    // valid never waits on ready; ready and valid here come only from registered full flags.
    logic [2:0]      wcnt;
    logic [2:0]      rcnt;
    logic            wbank;
    logic            rbank;
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic            in_fire;
    logic            out_fire;
    logic [1:0]      bank_we;
    logic [0:7][7:0] bank_dout [0:1];
    logic            bank_sel  [0:1];

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign bank_we[0] = in_fire & (wbank == 1'b0);
    assign bank_we[1] = in_fire & (wbank == 1'b1);

    // Fill and drain always target different banks, so set and clear never collide.
    always_comb begin
        full_nxt = full;
        if (in_fire && wcnt == 3'd7)
            full_nxt[wbank] = 1'b1;
        if (out_fire && rcnt == 3'd7)
            full_nxt[rbank] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt  <= 3'd0;
            rcnt  <= 3'd0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            full <= full_nxt;
            if (in_fire) begin
                wcnt <= wcnt + 3'd1;
                if (wcnt == 3'd7)
                    wbank <= ~wbank;
            end
            if (out_fire) begin
                rcnt <= rcnt + 3'd1;
                if (rcnt == 3'd7)
                    rbank <= ~rbank;
            end
        end
    end

    grostl_col_bank u_bank0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (bank_we[0]),
        .widx     (wcnt),
        .din      (din),
        .sel_q_in (in_sel_q),
        .ridx     (rcnt),
        .dout     (bank_dout[0]),
        .sel_q    (bank_sel[0])
    );

    grostl_col_bank u_bank1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (bank_we[1]),
        .widx     (wcnt),
        .din      (din),
        .sel_q_in (in_sel_q),
        .ridx     (rcnt),
        .dout     (bank_dout[1]),
        .sel_q    (bank_sel[1])
    );

    assign dout      = rbank ? bank_dout[1] : bank_dout[0];
    assign out_sel_q = rbank ? bank_sel[1]  : bank_sel[0];

endmodule

// File: tb/tb_grostl_shift_bytes.sv
// Self-checking bench for grostl_shift_bytes: directed vectors plus a random-handshake scoreboard run.
module tb_grostl_shift_bytes;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sel_q = 1'b0;
    logic [0:7][7:0] din = '0;
    logic            out_valid;
    logic            out_ready;
    logic            out_sel_q;
    logic [0:7][7:0] dout;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stall_cnt = 0;
    int last_acc  = 0;
    logic pre7_valid;

    logic [64:0] exp_q [$];
    logic [64:0] obs_q [$];
    logic [64:0] mon_got;

    logic rdy_mode  = 1'b0;
    logic rdy_fixed = 1'b1;

    logic [0:7][7:0] st [0:7];
    int sh_p [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int sh_q [8] = '{1, 3, 5, 7, 0, 2, 4, 6};

    grostl_shift_bytes dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel_q  (in_sel_q),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel_q (out_sel_q),
        .dout      (dout)
    );

    // clock / cycle counter / watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // downstream ready: fixed level or random toggling
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [127:0] act);
        n_checks++;
        $display("FAIL %s: got %h expected none", name, act);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            mon_got = {out_sel_q, dout};
            obs_q.push_back(mon_got);
            if (exp_q.size() == 0) fail("unexpected_out", 128'(mon_got));
            else check("out_col", 128'(mon_got), 128'(exp_q.pop_front()));
        end
    end

    // driver tasks (called at #1 after a rising edge)
    task automatic send_col(input logic [0:7][7:0] col, input logic sel, input int gap, output int acc);
        int waited;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        din      = col;
        in_sel_q = sel;
        waited   = 0;
        while (!in_ready && waited < 3000) begin
            @(posedge clk); #1;
            waited++;
            stall_cnt++;
        end
        if (!in_ready) begin
            fail("in_ready_timeout", 128'(waited));
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc      = cyc;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic build_state(input int mode);
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < 8; i++)
                st[c][i] = (mode == 0) ? {c[3:0], i[3:0]} : 8'($urandom_range(0, 255));
    endtask

    task automatic send_state(input logic sel, input int mode, input int gaps, output int acc0);
        logic [0:7][7:0] e;
        int acc;
        build_state(mode);
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 8; i++)
                e[i] = st[(c + (sel ? sh_q[i] : sh_p[i])) % 8][i];
            exp_q.push_back({sel, e});
        end
        acc0 = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 7) pre7_valid = out_valid;
            send_col(st[c], sel, gaps ? $urandom_range(0, 2) : 0, acc);
            if (c == 0) acc0 = acc;
        end
    endtask

    task automatic wait_drain(input int bound);
        int w = 0;
        while (exp_q.size() != 0 && w < bound) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  128'(in_ready),  128'd1);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_out_sel_q"}, 128'(out_sel_q), 128'd0);
        check({tag, "_dout"},      128'(dout),      128'd0);
    endtask

    initial begin
        int a0, a1, acc;

        // reset
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // P state, latency and hand-computed columns
        obs_q.delete();
        send_state(1'b0, 0, 0, a0);
        check("p_valid_before_col7", 128'(pre7_valid), 128'd0);
        @(negedge clk);
        check("p_valid_rise", 128'(out_valid), 128'd1);
        check("p_latency", 128'(cyc - a0), 128'd7);
        @(posedge clk); #1;
        wait_drain(100);
        check("p_count", 128'(obs_q.size()), 128'd8);
        if (obs_q.size() == 8) begin
            check("p_col0", 128'(obs_q[0]), 128'({1'b0, 64'h0011223344556677}));
            check("p_col7", 128'(obs_q[7]), 128'({1'b0, 64'h7001122334455667}));
        end

        // Q state
        obs_q.delete();
        send_state(1'b1, 0, 0, a0);
        wait_drain(100);
        check("q_count", 128'(obs_q.size()), 128'd8);
        if (obs_q.size() == 8)
            check("q_col0", 128'(obs_q[0]), 128'({1'b1, 64'h1031527304254667}));

        // back-to-back P then Q
        obs_q.delete();
        stall_cnt = 0;
        send_state(1'b0, 0, 0, a0);
        send_state(1'b1, 0, 0, a1);
        check("b2b_span", 128'(last_acc - a0), 128'd15);
        check("b2b_stalls", 128'(stall_cnt), 128'd0);
        wait_drain(100);
        check("b2b_count", 128'(obs_q.size()), 128'd16);
        if (obs_q.size() == 16) begin
            check("b2b_sel7", 128'(obs_q[7][64]), 128'd0);
            check("b2b_sel8", 128'(obs_q[8][64]), 128'd1);
        end

        // full backpressure
        rdy_fixed = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        send_state(1'b0, 0, 0, a0);
        send_state(1'b1, 0, 0, a1);
        in_valid = 1'b1;
        din      = '1;
        repeat (4) begin
            @(posedge clk); #1;
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_dout", 128'({out_sel_q, dout}), 128'({1'b0, 64'h0011223344556677}));
        end
        in_valid  = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain(200);

        // reset in the middle of a state
        build_state(0);
        for (int c = 0; c < 3; c++) send_col(st[c], 1'b1, 0, acc);
        #2 reset_n = 1'b0;
        #1 check_idle("midrst");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_idle("postrst");
        send_state(1'b0, 1, 0, a0);
        wait_drain(100);

        // random handshakes over 100 states
        rdy_mode = 1'b1;
        for (int s = 0; s < 100; s++)
            send_state(1'($urandom_range(0, 1)), 1, 1, a0);
        rdy_mode  = 1'b0;
        rdy_fixed = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        wait_drain(4000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/grostl_shift_bytes.md
# grostl_shift_bytes

Column-serial ShiftBytes stage for the 64-bit-datapath Grøstl-256 core. It sits directly downstream of the SubBytes stage and accepts one 64-bit state column per cycle, as eight row bytes. It buffers a complete 8×8-byte state and emits the eight columns with per-row cyclic column shifts applied. Two ping-pong banks sustain one column per cycle with a fixed 8-cycle latency.

## Interface
Parameters:
- none. Geometry is fixed at 8 columns × 8 rows × 8 bits by Grøstl-256.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  din column present
- in_ready  out  1  stage can accept a column
- in_sel_q  in  1  permutation select: 0 = P, 1 = Q; sampled with column 0 of each state
- din  in  [0:7][7:0]  column from SubBytes; index = row
- out_valid  out  1  dout column present
- out_ready  in  1  downstream accepts column
- out_sel_q  out  1  permutation select of the state being drained
- dout  out  [0:7][7:0]  shifted column; index = row

## Operation
- Input columns arrive in order 0..7; output columns leave in order 0..7. No framing signal exists: the column index is implied by the counters.
- Bank write: an input handshake (in_valid & in_ready) stores din into bank[wbank].col[wcnt] and increments wcnt (3-bit, wraps 7→0).
  - At wcnt == 0, in_sel_q is stored in bank[wbank].sel_q.
  - At wcnt == 7, full[wbank] is set and wbank toggles.
- Output: dout[i] = bank[rbank].col[(rcnt + SH[i]) mod 8][i], a combinational mux from registers. SH is SHIFT_P when bank sel_q = 0, otherwise SHIFT_Q.
  - SHIFT_P = {0,1,2,3,4,5,6,7}
  - SHIFT_Q = {1,3,5,7,0,2,4,6}
  - Mod-8 is the natural 3-bit wrap.
- Output handshake (out_valid & out_ready) increments rcnt. At rcnt == 7, full[rbank] is cleared and rbank toggles.
- in_ready = !full[wbank].
- out_valid = full[rbank].
- out_sel_q = bank[rbank].sel_q.
- Simultaneous events:
  - Set and clear of full in the same cycle always target different banks, and both take effect.
  - A full bank is never written.
  - A draining bank is never refilled until it is cleared.
  - Clearing a bank while the other bank fills is legal.
- Backpressure: while out_valid & !out_ready, dout and out_sel_q hold stable. The input side keeps filling the other bank until it is full, then in_ready drops.
- Reset (asynchronous, any time, including mid-state):
  - wcnt, rcnt, wbank, rbank, full[1:0], sel_q and all bank data clear to 0.
  - A partially written state is discarded.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_sel_q = 0, dout = 0.

## Timing
- Latency: column 0 accepted in cycle t, column 7 in cycle t+7. out_valid rises in cycle t+8 with output column 0.
- Throughput: one column per cycle sustained when out_ready is held at 1. in_ready never drops in that case.
- in_ready and out_valid are register-derived, with no combinational path from in_valid or out_ready.
- dout is a mux of registered bank data selected by registered counters.

## Structure
- grostl_pkg holds:
  - typedef col_t = logic [0:7][7:0]
  - typedef state_t = col_t [0:7]
  - localparam SHIFT_P and SHIFT_Q, each 3-bit × 8
- Sub-module grostl_col_bank holds one bank (state_t storage plus sel_q). It has a column write port (we, widx, din, sel_q) and the shifted read mux (ridx → dout). It is instantiated twice.
- The top level holds the counters, bank pointers, full flags and handshake logic, and selects dout from bank[rbank].

## Test plan
Stimulus pattern: input column c, row i carries byte 8'h{c,i}; for example column 3, row 5 = 8'h35.
- P permutation, out_ready = 1, sel_q = 0: output column 0 = {00,11,22,33,44,55,66,77}; output column 7 = {70,01,12,23,34,45,56,67}. out_valid is first high 8 cycles after column 0 is accepted.
- Q permutation, sel_q = 1: output column 0 = {10,31,52,73,04,25,46,67}; out_sel_q = 1 for all eight output columns.
- Back-to-back states P then Q, continuous valid, out_ready = 1: 16 inputs accepted in 16 cycles and in_ready never low. Outputs are P columns 0..7 then Q columns 0..7; out_sel_q switches at output 8.
- out_ready = 0 throughout: 16 columns accepted, then in_ready = 0 at the 17th. dout holds {00,11,…,77} stable. Releasing out_ready drains both states in order.
- Reset asserted after 3 input columns, then released: out_valid = 0, in_ready = 1, dout = 0. A fresh 8-column state then produces the correct column 0 without remnants of the aborted state.
- Random in_valid/out_ready toggling over 100 states with random sel_q: scoreboard compares every output column against the reference ShiftBytes model; no loss, duplication or reorder.
